// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main sequencer for the multi-cycle RV32I core. Each instruction moves through
// FETCH / DECODE / EXEC / MEM / WB. In every state the block drives the datapath
// mux selects and load enables, plus a 2-bit class code for the ALU control
// decoder (00 add for load/store/address, 01 branch-sub, 10 R-type, 11 I-type).
//
// The three memory states (FETCH, MEM_RD, MEM_WR) wait on mem_ready. Each has a
// bounded wait, and running out of time sends the core to TRAP. An illegal
// opcode in DECODE also traps. TRAP is held until reset.
//
// Parameters
//   MEM_TIMEOUT    highest wait count allowed in a memory state (1..255)
//
// Ports
//   clk            core clock; every state change happens on the rising edge
//   rst            synchronous, active-high reset
//   opcode[6:0]    IR[6:0], valid from DECODE onward
//   mem_ready      memory completes the current access this cycle
//   branch_taken   comparator result, used in BRANCH
//   pc_write       PC load enable
//   pc_src         0 = ALU result (PC+4), 1 = ALUOut (branch/jump target)
//   ir_write       IR load enable
//   i_or_d         memory address select: 0 = PC, 1 = ALUOut
//   mem_read       memory read request
//   mem_write      memory write request
//   reg_write      register file write enable
//   mem_to_reg     writeback select: 00 ALUOut, 01 MDR, 10 PC (link)
//   alu_src_a      00 PC, 01 rs1, 10 old PC
//   alu_src_b      00 rs2, 01 constant 4, 10 immediate
//   alu_control    class code for the ALU control decoder
//   instr_retired  one-cycle pulse on the last cycle of a completed instruction
//   trap           high while in TRAP
//   trap_cause     01 illegal opcode, 10 memory timeout, 00 none
//   state_dbg      current state encoding
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic       instr_retired,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wait_cnt;
  logic [1:0] cause_q, cause_next;
  logic       mem_wait_state;
  logic       timed_out;

  // The wait counter only moves while a memory state is stalled. It goes back
  // to zero whenever the state changes, which covers every entry into a wait.
  assign mem_wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // If mem_ready arrives in the same cycle the limit is reached, the access
  // completes normally.
  assign timed_out      = mem_wait_state && !mem_ready && (wait_cnt == TIMEOUT_LIMIT);
  assign state_dbg      = state;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state_next != state) begin
        wait_cnt <= '0;
      end else if (mem_wait_state && !mem_ready) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // NOTE: every output and next-state signal gets a default before the case,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    cause_next    = cause_q;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_control   = 2'b00;
    instr_retired = 1'b0;
    trap          = 1'b0;
    trap_cause    = cause_q;

    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          // Instruction load and PC+4 update happen in the completing cycle.
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        // Branch/jump target (old PC + imm) is computed into ALUOut here.
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        case (opcode)
          OP_R_TYPE:          state_next = S_EXEC_R;
          OP_I_TYPE:          state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_MEM_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          default: begin
            state_next = S_TRAP;
            cause_next = CAUSE_ILLEGAL;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a   = 2'b01;
        alu_control = 2'b10;
        state_next  = S_ALU_WB;
      end

      S_EXEC_I: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = 2'b11;
        state_next  = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        // opcode[5] separates stores (0100011) from loads (0000011).
        state_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_next = S_MEM_WB;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_next    = S_FETCH;
        end else if (timed_out) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 2'b01;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a     = 2'b01;
        alu_control   = 2'b01;
        pc_write      = branch_taken;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      S_JAL: begin
        reg_write     = 1'b1;
        mem_to_reg    = 2'b10;
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_FETCH;
      end

      S_TRAP: begin
        trap = 1'b1;
      end

      default: state_next = S_FETCH;
    endcase

    // While reset is held, every output shows its reset value. This keeps an
    // interrupted store or writeback from completing in the reset cycle.
    if (rst) begin
      pc_write      = 1'b0;
      pc_src        = 1'b0;
      ir_write      = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_control   = 2'b00;
      instr_retired = 1'b0;
      trap          = 1'b0;
      trap_cause    = CAUSE_NONE;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed bench for the multi-cycle control sequencer. A behavioural model
// tracks the instruction phase and the memory wait count, built from the
// per-phase output table and the sequencing rules. A compare process checks
// every DUT output against that model on each falling edge. Literal checks in
// the stimulus pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam int unsigned TMO = 15;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Phase numbers as seen on state_dbg.
  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC_R = 2, P_EXEC_I = 3;
  localparam int P_MEM_ADDR = 4, P_MEM_RD = 5, P_MEM_WB = 6, P_MEM_WR = 7;
  localparam int P_ALU_WB = 8, P_BRANCH = 9, P_JAL = 10, P_TRAP = 15;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic       instr_retired;
    logic       trap;
    logic [1:0] trap_cause;
    logic [3:0] state_dbg;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_control;
  logic       instr_retired, trap;
  logic [1:0] trap_cause;
  logic [3:0] state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  multicycle_control_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_control   (alu_control),
    .instr_retired (instr_retired),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  obs_t       tbl [16];
  int         m_state = 0;
  int         m_cnt   = 0;
  logic [1:0] m_cause = 2'b00;
  bit         m_valid = 1'b0;

  // Outputs each phase drives on its own, before any input-dependent terms.
  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tbl[P_FETCH].mem_read      = 1'b1;
    tbl[P_FETCH].alu_src_b     = 2'b01;
    tbl[P_DECODE].alu_src_a    = 2'b10;
    tbl[P_DECODE].alu_src_b    = 2'b10;
    tbl[P_EXEC_R].alu_src_a    = 2'b01;
    tbl[P_EXEC_R].alu_control  = 2'b10;
    tbl[P_EXEC_I].alu_src_a    = 2'b01;
    tbl[P_EXEC_I].alu_src_b    = 2'b10;
    tbl[P_EXEC_I].alu_control  = 2'b11;
    tbl[P_ALU_WB].reg_write    = 1'b1;
    tbl[P_ALU_WB].instr_retired = 1'b1;
    tbl[P_MEM_ADDR].alu_src_a  = 2'b01;
    tbl[P_MEM_ADDR].alu_src_b  = 2'b10;
    tbl[P_MEM_RD].mem_read     = 1'b1;
    tbl[P_MEM_RD].i_or_d       = 1'b1;
    tbl[P_MEM_WR].mem_write    = 1'b1;
    tbl[P_MEM_WR].i_or_d       = 1'b1;
    tbl[P_MEM_WB].reg_write    = 1'b1;
    tbl[P_MEM_WB].mem_to_reg   = 2'b01;
    tbl[P_MEM_WB].instr_retired = 1'b1;
    tbl[P_BRANCH].alu_src_a    = 2'b01;
    tbl[P_BRANCH].alu_control  = 2'b01;
    tbl[P_BRANCH].pc_src       = 1'b1;
    tbl[P_BRANCH].instr_retired = 1'b1;
    tbl[P_JAL].reg_write       = 1'b1;
    tbl[P_JAL].mem_to_reg      = 2'b10;
    tbl[P_JAL].pc_write        = 1'b1;
    tbl[P_JAL].pc_src          = 1'b1;
    tbl[P_JAL].instr_retired   = 1'b1;
    tbl[P_TRAP].trap           = 1'b1;
  end

  // Compare on the falling edge, then advance the model to the next phase.
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    int   nxt;
    if (m_valid) begin
      e = tbl[m_state];
      if (m_state == P_FETCH && mem_ready) begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
      end
      if (m_state == P_MEM_WR && mem_ready) e.instr_retired = 1'b1;
      if (m_state == P_BRANCH) e.pc_write = branch_taken;
      e.trap_cause = m_cause;
      if (rst) e = '0;
      e.state_dbg = 4'(m_state);
      a = '{pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
            mem_to_reg, alu_src_a, alu_src_b, alu_control, instr_retired, trap,
            trap_cause, state_dbg};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t phase=%0d got=%h want=%h", $time, m_state, a, e);
      end
    end

    if (rst) begin
      m_state = P_FETCH;
      m_cnt   = 0;
      m_cause = 2'b00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      nxt = m_state;
      if (m_state == P_FETCH || m_state == P_MEM_RD || m_state == P_MEM_WR) begin
        if (mem_ready) begin
          nxt = (m_state == P_FETCH)  ? P_DECODE :
                (m_state == P_MEM_RD) ? P_MEM_WB : P_FETCH;
        end else if (m_cnt == TMO) begin
          nxt     = P_TRAP;
          m_cause = 2'b10;
        end else begin
          m_cnt++;
        end
      end else if (m_state == P_DECODE) begin
        if (opcode == OP_R)                        nxt = P_EXEC_R;
        else if (opcode == OP_I)                   nxt = P_EXEC_I;
        else if (opcode == OP_LW || opcode == OP_SW) nxt = P_MEM_ADDR;
        else if (opcode == OP_BR)                  nxt = P_BRANCH;
        else if (opcode == OP_JAL)                 nxt = P_JAL;
        else begin
          nxt     = P_TRAP;
          m_cause = 2'b01;
        end
      end else if (m_state == P_EXEC_R || m_state == P_EXEC_I) begin
        nxt = P_ALU_WB;
      end else if (m_state == P_MEM_ADDR) begin
        nxt = opcode[5] ? P_MEM_WR : P_MEM_RD;
      end else if (m_state != P_TRAP) begin
        nxt = P_FETCH;
      end
      if (nxt != m_state) m_cnt = 0;
      m_state = nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, then return just after the falling edge.
  task automatic drive(input logic r, input logic [6:0] op, input logic rdy, input logic tk);
    @(posedge clk);
    #1;
    rst          = r;
    opcode       = op;
    mem_ready    = rdy;
    branch_taken = tk;
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(1, '0, 0, 0);
    drive(1, '0, 0, 0);
    check("reset_state", state_dbg, 0);
    check("reset_mem_read", mem_read, 0);

    // ADD: FETCH, DECODE, EXEC_R, ALU_WB
    drive(0, OP_R, 1, 0);
    check("add_fetch_state", state_dbg, 0);
    check("add_fetch_ir_write", ir_write, 1);
    drive(0, OP_R, 1, 0);
    check("add_decode_state", state_dbg, 1);
    drive(0, OP_R, 1, 0);
    check("add_exec_state", state_dbg, 2);
    check("add_exec_aluctl", alu_control, 2'b10);
    check("add_exec_no_wr", reg_write, 0);
    drive(0, OP_R, 1, 0);
    check("add_wb_state", state_dbg, 8);
    check("add_wb_reg_write", reg_write, 1);
    check("add_retired_c4", instr_retired, 1);

    // LW with three stalled cycles in MEM_RD
    drive(0, OP_LW, 1, 0);
    drive(0, OP_LW, 1, 0);
    drive(0, OP_LW, 1, 0);
    check("lw_addr_state", state_dbg, 4);
    for (int i = 0; i < 3; i++) begin
      drive(0, OP_LW, 0, 0);
      check("lw_stall_state", state_dbg, 5);
    end
    drive(0, OP_LW, 1, 0);
    check("lw_rd_state", state_dbg, 5);
    check("lw_rd_i_or_d", i_or_d, 1);
    drive(0, OP_LW, 1, 0);
    check("lw_wb_state", state_dbg, 6);
    check("lw_wb_mem_to_reg", mem_to_reg, 2'b01);
    check("lw_no_trap", trap, 0);

    // BEQ taken, then not taken
    drive(0, OP_BR, 1, 1);
    drive(0, OP_BR, 1, 1);
    drive(0, OP_BR, 1, 1);
    check("beq_t_state", state_dbg, 9);
    check("beq_t_pc_write", pc_write, 1);
    check("beq_t_pc_src", pc_src, 1);
    check("beq_t_aluctl", alu_control, 2'b01);
    drive(0, OP_BR, 1, 0);
    drive(0, OP_BR, 1, 0);
    drive(0, OP_BR, 1, 0);
    check("beq_nt_state", state_dbg, 9);
    check("beq_nt_pc_write", pc_write, 0);
    check("beq_nt_aluctl", alu_control, 2'b01);

    // I-type
    drive(0, OP_I, 1, 0);
    drive(0, OP_I, 1, 0);
    drive(0, OP_I, 1, 0);
    check("addi_exec_state", state_dbg, 3);
    check("addi_exec_aluctl", alu_control, 2'b11);
    drive(0, OP_I, 1, 0);
    check("addi_retired", instr_retired, 1);

    // JAL
    drive(0, OP_JAL, 1, 0);
    drive(0, OP_JAL, 1, 0);
    drive(0, OP_JAL, 1, 0);
    check("jal_state", state_dbg, 10);
    check("jal_mem_to_reg", mem_to_reg, 2'b10);
    check("jal_pc_write", pc_write, 1);

    // SW, immediate completion
    for (int i = 0; i < 4; i++) drive(0, OP_SW, 1, 0);
    check("sw_state", state_dbg, 7);
    check("sw_mem_write", mem_write, 1);
    check("sw_retired", instr_retired, 1);

    // SW interrupted by reset while waiting in MEM_WR
    for (int i = 0; i < 3; i++) drive(0, OP_SW, 1, 0);
    drive(0, OP_SW, 0, 0);
    check("swr_wait_state", state_dbg, 7);
    check("swr_wait_mem_write", mem_write, 1);
    drive(1, OP_SW, 0, 0);
    check("swr_rst_mem_write", mem_write, 0);
    drive(0, OP_R, 0, 0);
    check("swr_after_state", state_dbg, 0);
    check("swr_after_mem_write", mem_write, 0);
    check("swr_after_trap", trap, 0);

    // That FETCH was unready cycle 1; 15 more reach the limit -> TRAP cause 10
    for (int i = 2; i <= 16; i++) drive(0, OP_R, 0, 0);
    check("fto_16th_state", state_dbg, 0);
    drive(0, OP_R, 1, 0);
    check("fto_trap_state", state_dbg, 15);
    check("fto_trap", trap, 1);
    check("fto_cause", trap_cause, 2'b10);
    drive(1, OP_R, 0, 0);

    // Ready arriving on the 16th FETCH cycle wins over the timeout
    for (int i = 1; i <= 15; i++) drive(0, OP_R, 0, 0);
    drive(0, OP_R, 1, 0);
    check("frdy_16th_ir_write", ir_write, 1);
    drive(0, OP_R, 1, 0);
    check("frdy_decode_state", state_dbg, 1);
    drive(0, OP_R, 1, 0);
    drive(0, OP_R, 1, 0);
    check("frdy_add_retired", instr_retired, 1);

    // Illegal opcode -> TRAP cause 01, held for 20 cycles
    drive(0, OP_BAD, 1, 1);
    drive(0, OP_BAD, 1, 1);
    check("ill_decode_state", state_dbg, 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, OP_BAD, 1, 1);
      check("ill_trap_state", state_dbg, 15);
      check("ill_cause", trap_cause, 2'b01);
      check("ill_pc_write", pc_write, 0);
      check("ill_reg_write", reg_write, 0);
    end
    drive(1, OP_BAD, 1, 1);
    drive(0, OP_R, 0, 0);
    check("ill_rst_state", state_dbg, 0);
    check("ill_rst_trap", trap, 0);
    check("ill_rst_cause", trap_cause, 2'b00);
    drive(0, OP_R, 1, 0);
    drive(0, OP_R, 1, 0);
    drive(0, OP_R, 1, 0);
    drive(0, OP_R, 1, 0);

    // Load whose data never arrives -> timeout out of MEM_RD
    drive(0, OP_LW, 1, 0);
    drive(0, OP_LW, 1, 0);
    drive(0, OP_LW, 1, 0);
    for (int i = 0; i < 16; i++) drive(0, OP_LW, 0, 0);
    check("rto_16th_state", state_dbg, 5);
    drive(0, OP_LW, 0, 0);
    check("rto_trap_state", state_dbg, 15);
    check("rto_cause", trap_cause, 2'b10);
    check("rto_reg_write", reg_write, 0);
    drive(1, OP_LW, 0, 0);
    drive(0, OP_R, 0, 0);
    drive(0, OP_R, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
